// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions.
// Opcode constants and controller state encoding.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_RSB = 4'd2;
  localparam logic [3:0] OP_BIC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_XNR = 4'd7;
  localparam logic [3:0] OP_LSL = 4'd8;
  localparam logic [3:0] OP_LSR = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_MVN = 4'd14;
  localparam logic [3:0] OP_RSV = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu request/response bundle.
// master drives requests, slave is the ALU.
interface seq_alu_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   I;
  logic         S;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] F;
  logic         C_out;
  logic         OVF;
  logic         Z;
  logic         N;

  modport master (
    output in_valid, A, B, I, S, out_ready,
    input  in_ready, out_valid, F,
    input  C_out, OVF, Z, N
  );

  modport slave (
    input  in_valid, A, B, I, S, out_ready,
    output in_ready, out_valid, F,
    output C_out, OVF, Z, N
  );
endinterface

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier, low W bits.
// P/done expose the final iteration's result combinationally.
module seq_alu_mul #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         done,
  output logic [W-1:0] P
);
  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  p_q;
  logic [W-1:0]  p_nxt;
  logic [CW-1:0] cnt;

  assign p_nxt = b_q[0] ? p_q + a_q : p_q;
  assign P     = p_nxt;
  assign done  = (cnt == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      cnt <= '0;
    end else if (start) begin
      a_q <= A;
      b_q <= B;
      p_q <= '0;
      cnt <= CW'(W);
    end else if (cnt != '0) begin
      a_q <= a_q << 1;
      b_q <= b_q >> 1;
      p_q <= p_nxt;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: one-cycle ops plus iterative MUL,
// valid/ready request and response with registered flags.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int W      = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);
  localparam int LW = $clog2(W);
  localparam int CW = LW + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          s_q;
  logic [W-1:0]  f_q;
  logic          c_q, v_q, z_q, n_q;

  logic [W-1:0]   a, b, r;
  logic [3:0]     op;
  logic [LW-1:0]  sh;
  logic           rc, rv;
  logic [W:0]     ext;
  logic [2*W-1:0] dbl;
  logic           is_mul, start, mul_done;
  logic [W-1:0]   prod;

  assign a      = bus.A;
  assign b      = bus.B;
  assign op     = bus.I;
  assign sh     = bus.B[LW-1:0];
  assign is_mul = MUL_EN && (op == OP_MUL);
  assign start  = (state == IDLE) && bus.in_valid && is_mul;

  seq_alu_mul #(.W(W)) u_mul (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .A    (a),
    .B    (b),
    .done (mul_done),
    .P    (prod)
  );

  // Flags not produced by an op default to their held value.
  always_comb begin
    r   = '0;
    rc  = c_q;
    rv  = v_q;
    ext = '0;
    dbl = '0;
    unique case (1'b1)
      op == OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        r   = ext[W-1:0];
        rc  = ext[W];
        rv  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      op == OP_SUB: begin
        ext = {1'b0, a} - {1'b0, b};
        r   = ext[W-1:0];
        rc  = ext[W];
        rv  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      op == OP_RSB: begin
        ext = {1'b0, b} - {1'b0, a};
        r   = ext[W-1:0];
        rc  = ext[W];
        rv  = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]);
      end
      op == OP_BIC: r = a & ~b;
      op == OP_AND: r = a & b;
      op == OP_OR:  r = a | b;
      op == OP_XOR: r = a ^ b;
      op == OP_XNR: r = ~(a ^ b);
      op == OP_LSL: begin
        ext = {1'b0, a} << sh;
        r   = ext[W-1:0];
        if (sh != '0) rc = ext[W];
      end
      op == OP_LSR: begin
        ext = {a, 1'b0} >> sh;
        r   = ext[W:1];
        if (sh != '0) rc = ext[0];
      end
      op == OP_ASR: begin
        ext = $signed({a, 1'b0}) >>> sh;
        r   = ext[W:1];
        if (sh != '0) rc = ext[0];
      end
      op == OP_ROR: begin
        dbl = {a, a} >> sh;
        r   = dbl[W-1:0];
        if (sh != '0) rc = r[W-1];
      end
      op == OP_MOV: r = b;
      op == OP_MVN: r = ~b;
      default:      r = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      s_q   <= 1'b0;
      f_q   <= '0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
      z_q   <= 1'b1;
      n_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          s_q <= bus.S;
          if (is_mul) begin
            state <= BUSY;
            cnt   <= CW'(W);
          end else begin
            state <= DONE;
            f_q   <= r;
            if (bus.S) begin
              c_q <= rc;
              v_q <= rv;
              z_q <= (r == '0);
              n_q <= r[W-1];
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1) && mul_done) begin
            state <= DONE;
            f_q   <= prod;
            if (s_q) begin
              z_q <= (prod == '0);
              n_q <= prod[W-1];
            end
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.F         = f_q;
  assign bus.C_out     = c_q;
  assign bus.OVF       = v_q;
  assign bus.Z         = z_q;
  assign bus.N         = n_q;
endmodule

// File: tb/tb_seq_alu.sv
// seq_alu bench: directed vectors, expected results
// queued by the driver and popped by an output monitor.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 8;

  typedef struct {
    string      nm;
    logic [7:0] f;
    logic       c, v, z, n;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  seq_alu_if #(.W(W)) bus ();

  seq_alu #(.W(W), .MUL_EN(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got F=%0h required none",
                 bus.F);
      end else begin
        e = q.pop_front();
        chk({e.nm, "_F"}, 32'(bus.F), 32'(e.f));
        chk({e.nm, "_C"}, 32'(bus.C_out), 32'(e.c));
        chk({e.nm, "_V"}, 32'(bus.OVF), 32'(e.v));
        chk({e.nm, "_Z"}, 32'(bus.Z), 32'(e.z));
        chk({e.nm, "_N"}, 32'(bus.N), 32'(e.n));
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready=0 required 1");
    end
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b,
                       input logic s,
                       input string nm,
                       input logic [7:0] f,
                       input logic c, v, z, n);
    exp_t e;
    wait_ready();
    e.nm = nm; e.f = f;
    e.c = c; e.v = v; e.z = z; e.n = n;
    q.push_back(e);
    bus.in_valid = 1'b1;
    bus.A = a; bus.B = b;
    bus.I = op; bus.S = s;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A = ~a;
    bus.B = 8'($urandom);
    bus.I = 4'($urandom);
    bus.S = ~s;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, lo;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.A = '0; bus.B = '0;
    bus.I = '0; bus.S = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_F", 32'(bus.F), 32'h0);
    chk("rst_Z", 32'(bus.Z), 32'h1);
    chk("rst_CVN", 32'({bus.C_out, bus.OVF, bus.N}), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_ready", 32'(bus.in_ready), 32'h1);

    issue(OP_ADD, 8'h7F, 8'h01, 1, "add_ovf", 8'h80, 0, 1, 0, 1);
    chk("add_lat", 32'(bus.out_valid), 32'h1);
    issue(OP_SUB, 8'h00, 8'h01, 1, "sub_brw", 8'hFF, 1, 0, 0, 1);
    issue(OP_AND, 8'hF0, 8'h0F, 0, "and_s0", 8'h00, 1, 0, 0, 1);
    issue(OP_LSL, 8'h81, 8'h01, 1, "lsl", 8'h02, 1, 0, 0, 0);
    issue(OP_ASR, 8'h80, 8'h03, 1, "asr", 8'hF0, 0, 0, 0, 1);

    issue(OP_MUL, 8'h0F, 8'h11, 1, "mul", 8'hFF, 0, 0, 0, 1);
    lat = 1; lo = 0;
    while (!bus.out_valid && lat < 40) begin
      if (!bus.in_ready) lo++;
      bus.in_valid = lat[0];
      bus.I = OP_ADD;
      bus.A = 8'h01; bus.B = 8'h01;
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    if (!bus.in_ready) lo++;
    chk("mul_latency", 32'(lat), 32'd9);
    chk("mul_ready_low", 32'(lo), 32'd9);

    issue(OP_RSB, 8'h05, 8'h03, 1, "rsb", 8'hFE, 1, 0, 0, 1);
    issue(OP_BIC, 8'hFF, 8'h0F, 1, "bic", 8'hF0, 1, 0, 0, 1);
    issue(OP_OR,  8'h00, 8'h00, 1, "or0", 8'h00, 1, 0, 1, 0);
    issue(OP_XOR, 8'hA5, 8'h5A, 0, "xor", 8'hFF, 1, 0, 1, 0);
    issue(OP_XNR, 8'hA5, 8'h5A, 1, "xnor", 8'h00, 1, 0, 1, 0);
    issue(OP_LSR, 8'h03, 8'h01, 1, "lsr", 8'h01, 1, 0, 0, 0);
    issue(OP_ROR, 8'h01, 8'h01, 1, "ror", 8'h80, 1, 0, 0, 1);
    issue(OP_LSL, 8'h80, 8'h08, 1, "lsl_sh0", 8'h80, 1, 0, 0, 1);
    issue(OP_MOV, 8'h55, 8'h00, 1, "mov", 8'h00, 1, 0, 1, 0);
    issue(OP_MVN, 8'h55, 8'h00, 1, "mvn", 8'hFF, 1, 0, 0, 1);
    issue(OP_RSV, 8'h12, 8'h34, 1, "rsv", 8'h00, 1, 0, 1, 0);
    issue(OP_SUB, 8'h80, 8'h01, 1, "sub_ovf", 8'h7F, 0, 1, 0, 0);
    issue(OP_ADD, 8'hFF, 8'h01, 1, "add_cry", 8'h00, 1, 0, 1, 0);

    wait_ready();
    bus.out_ready = 1'b0;
    issue(OP_ADD, 8'h01, 8'h02, 0, "hold", 8'h03, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(bus.out_valid), 32'h1);
      chk("hold_ready", 32'(bus.in_ready), 32'h0);
      chk("hold_F", 32'(bus.F), 32'h03);
      chk("hold_flags",
          32'({bus.C_out, bus.OVF, bus.Z, bus.N}), 32'b1010);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", 32'(bus.in_ready), 32'h1);
    chk("release_valid", 32'(bus.out_valid), 32'h0);

    bus.in_valid = 1'b1;
    bus.I = OP_MUL; bus.A = 8'h0F; bus.B = 8'h11; bus.S = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_ready", 32'(bus.in_ready), 32'h1);
    chk("arst_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_Z", 32'(bus.Z), 32'h1);
    chk("arst_F", 32'(bus.F), 32'h0);
    chk("arst_CVN", 32'({bus.C_out, bus.OVF, bus.N}), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("post_rst_ready", 32'(bus.in_ready), 32'h1);
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_quiet", 32'(bus.out_valid), 32'h0);
    issue(OP_ADD, 8'h01, 8'h01, 1, "add_post", 8'h02, 0, 0, 0, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter W, default 8: operand/result width, W >= 4, power of two.
REQ-002 Parameter MUL_EN, default 1: 1 enables opcode MUL; 0 makes MUL behave as reserved.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 A  input  W  first operand.
REQ-008 B  input  W  second operand; shift amount is B[log2(W)-1:0].
REQ-009 I  input  4  opcode.
REQ-010 S  input  1  set-flags request for this operation.
REQ-011 out_valid  output  1  result F is valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 F  output  W  registered result.
REQ-014 C_out, OVF, Z, N  output  1 each  registered flag state: carry/borrow, signed overflow, zero, negative.

Function
REQ-015 Opcodes 0-7 SHALL be ADD A+B, SUB A-B, RSB B-A, BIC A&~B, AND, OR, XOR, XNOR.
REQ-016 ADD/SUB/RSB SHALL set C_out to bit W of the (W+1)-bit unsigned result (borrow for SUB/RSB) and OVF to two's-complement overflow.
REQ-017 Opcodes 8-11 SHALL be LSL, LSR, ASR and ROR of A by sh = B[log2(W)-1:0].
REQ-018 Shifts with sh>0 SHALL set C_out to the last bit shifted out; ROR SHALL set C_out to F[W-1]; sh=0 SHALL leave C_out unchanged.
REQ-019 Opcode 12 MUL SHALL produce the low W bits of unsigned A*B over exactly W shift-add iterations.
REQ-020 Opcode 13 MOV SHALL give F=B, opcode 14 MVN F=~B; opcode 15 (and MUL with MUL_EN=0) SHALL give F=0.
REQ-021 Logic, move, MUL and reserved opcodes SHALL leave C_out and OVF unchanged; shifts SHALL leave OVF unchanged.
REQ-022 Z and N SHALL be computed from the new F.
REQ-023 When S=1, all four flags SHALL be updated with the new values; when S=0, all four SHALL hold their previous values.
REQ-024 The FSM SHALL have three states, IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-025 IDLE with in_valid=1: the opcode SHALL be accepted; a non-MUL opcode goes to DONE; MUL goes to BUSY with the iteration counter set to W.
REQ-026 BUSY SHALL decrement the counter each cycle and go to DONE on the cycle the counter reaches 0; in_valid SHALL be ignored in BUSY.
REQ-027 Latency SHALL be 1 cycle for non-MUL opcodes (out_valid on the cycle after acceptance) and W+1 cycles for MUL.
REQ-028 DONE SHALL drive out_valid=1 with F and flags stable until out_ready=1, then go to IDLE.
REQ-029 out_ready=1 in DONE SHALL NOT allow acceptance of a new request in the same cycle; the maximum rate is one operation per 2 cycles.
REQ-030 Operands, opcode and S SHALL be captured at acceptance; later changes to the inputs SHALL have no effect on the result.

Reset
REQ-031 reset SHALL force, asynchronously: state IDLE, out_valid=0, F=0, C_out=OVF=N=0, Z=1, counter 0.
REQ-032 reset asserted in BUSY or DONE SHALL discard the operation; no out_valid pulse SHALL follow reset release.
REQ-033 in_ready SHALL be 1 on the first cycle after reset release.

Structure
REQ-034 Opcode constants (4-bit) and the state encoding SHALL reside in the shared package seq_alu_pkg.
REQ-035 The iterative multiplier SHALL be the sub-module seq_alu_mul, with ports start, A, B, done and P.
REQ-036 Combinational ops SHALL be one decode block feeding the result/flag registers; no latches.

Verification (W=8)
REQ-037 ADD A=7F B=01 S=1 -> one cycle later out_valid, F=80, N=1, OVF=1, C_out=0, Z=0.
REQ-038 SUB A=00 B=01 S=1 -> F=FF, C_out=1, OVF=0; then AND A=F0 B=0F S=0 -> F=00, flags still C=1 N=1 Z=0.
REQ-039 MUL A=0F B=11 -> in_ready low 9 cycles, out_valid on cycle 9, F=FF; in_valid pulses during BUSY ignored.
REQ-040 LSL A=81 B=01 S=1 -> F=02, C_out=1; ASR A=80 B=03 S=1 -> F=F0, C_out=0, N=1.
REQ-041 out_ready held 0 for 5 cycles in DONE -> F and flags stable, in_ready=0; out_ready=1 -> IDLE the next cycle.
REQ-042 reset asserted 4 cycles into MUL -> immediate IDLE, Z=1, out_valid=0; a following ADD 01+01 -> F=02.
